hpdcache_mem_responder: RTL and testbench
=========================================

HPDCACHE_MEM_RESPONDER -- requirements
Module: hpdcache_mem_responder

Interface
REQ-001 SHALL have parameter PA_WIDTH, default 56: physical address width in bits.
REQ-002 SHALL have parameter WORD_WIDTH, default 64: data word width in bits.
REQ-003 SHALL have parameter CL_WORDS, default 2: words per cache line.
REQ-004 SHALL have parameter BEAT_WORDS, default 1: words per response beat; it divides CL_WORDS, and NBEATS = CL_WORDS/BEAT_WORDS.
REQ-005 SHALL have parameter ID_WIDTH, default 4: transaction ID width in bits.
REQ-006 SHALL have parameter MEM_LINES, default 64, power of two: number of cache lines held in the backing store.
REQ-007 SHALL have parameter REQ_FIFO_DEPTH, default 2: request FIFO entries.
REQ-008 SHALL have parameter LATENCY, default 2: wait cycles between request pop and the first response beat; 0 is legal.
REQ-009 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-010 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-011 SHALL have ports req_valid_i input 1 and req_ready_o output 1: request handshake.
REQ-012 SHALL have port req_op_i, input, 1 bit: 0 = cache-line read (refill), 1 = single-word write.
REQ-013 SHALL have ports req_addr_i input PA_WIDTH and req_id_i input ID_WIDTH: request address and transaction ID.
REQ-014 SHALL have ports req_wdata_i input WORD_WIDTH and req_be_i input WORD_WIDTH/8: write data and byte enables.
REQ-015 SHALL have ports rsp_valid_o output 1 and rsp_ready_i input 1: response handshake.
REQ-016 SHALL have ports rsp_id_o output ID_WIDTH, rsp_data_o output BEAT_WORDS*WORD_WIDTH, rsp_last_o output 1, rsp_is_write_o output 1 and rsp_error_o output 1.

Function
REQ-017 SHALL accept a request on any cycle where req_valid_i and req_ready_o are both high.
- req_ready_o = !fifo_full, computed from registered state.
- No same-cycle bypass when the FIFO is full, even if the FIFO also pops that cycle.
REQ-018 SHALL serve requests strictly in acceptance order; a read observes every earlier accepted write.
REQ-019 SHALL use FSM states IDLE, WAIT and SEND:
- IDLE with FIFO non-empty: pop the head; go to WAIT with cnt = LATENCY, or go directly to SEND when LATENCY = 0.
- WAIT: decrement cnt each cycle; go to SEND on the cycle cnt reaches 1.
- SEND: after the last handshake, return to IDLE (one idle cycle between responses).
REQ-020 SHALL derive the line index as req_addr_i[log2(CL_WORDS*WORD_WIDTH/8) +: log2(MEM_LINES)].
REQ-021 SHALL derive the word index as the next-lower log2(CL_WORDS) bits above the byte offset.
REQ-022 SHALL return a read as NBEATS beats, lowest-addressed beat first.
- Each beat completes on rsp_valid_o && rsp_ready_i.
- rsp_last_o is high only on beat NBEATS-1.
- rsp_is_write_o = 0 on every beat.
REQ-023 SHALL apply a write byte-wise under req_be_i at pop time.
- Response is a single beat: rsp_last_o = 1, rsp_is_write_o = 1, rsp_data_o = 0.
REQ-024 SHALL hold rsp_data_o, rsp_id_o, rsp_last_o, rsp_is_write_o and rsp_error_o stable while rsp_valid_o = 1 and rsp_ready_i = 0.
REQ-025 SHALL drive rsp_valid_o low in the IDLE and WAIT states.
REQ-026 SHALL support a simultaneous FIFO push and pop on the same cycle without loss of either request.

Reset
REQ-027 SHALL, while rst_ni = 0 (asynchronously, including mid-transaction), hold the FSM in IDLE, empty the FIFO and clear the beat counter and cnt.
REQ-028 SHALL drive all response outputs to 0 and req_ready_o to 0 during reset; req_ready_o goes to 1 on the first clock after reset is released.
REQ-029 SHALL reset all backing-store contents to 0.
REQ-030 SHALL discard an in-flight response at reset; no partial beat appears after reset release.

Configuration
REQ-031 SHALL compile the address-range check only when macro HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN is defined.
- With the macro, any address >= MEM_LINES*CL_WORDS*WORD_WIDTH/8 is out of range.
- Out-of-range read: NBEATS beats with zero data and rsp_error_o = 1 on every beat.
- Out-of-range write: store not modified, rsp_error_o = 1.
REQ-032 SHALL, without HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN, ignore upper address bits (address wraps modulo the store size) and tie rsp_error_o to 0.

Verification
REQ-033 Write 0x1122334455667788 at 0x40 (be = 0xFF, id 3), then read 0x40 (id 4) with defaults -> write response id 3 last = 1; then read beats 0x1122334455667788 and 0x0, id 4, last on beat 1.
REQ-034 Request pop with LATENCY = 2 -> first rsp_valid_o exactly 3 cycles after the accepting cycle.
REQ-035 Hold rsp_ready_i = 0 for 5 cycles during a read -> outputs stable; 3 requests issued back-to-back -> req_ready_o = 0 after 2 accepts.
REQ-036 Write with be = 0x0F to a line holding all-ones -> subsequent read shows only the low 4 bytes replaced.
REQ-037 With the macro, read at 0x1000 -> 2 beats, data 0, rsp_error_o = 1; without the macro, the same read returns line 0.
REQ-038 Assert rst_ni = 0 mid-beat-1 -> rsp_valid_o = 0 immediately; after release, req_ready_o = 1 and a read of 0x40 returns 0.

Source files
------------

// File: rtl/hpdcache_mem_responder.sv
// Memory-side responder for the HPDcache refill and write path.
// It queues requests in a small FIFO and serves them in acceptance order from a
// backing store that resets to zero. A read returns a full cache line in beats;
// a write updates one word under byte enables and returns a single beat.
// Optional feature: define HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN to flag
// addresses beyond the store with rsp_error_o. Without it, addresses wrap.
module hpdcache_mem_responder #(
  parameter int unsigned PA_WIDTH       = 56,
  parameter int unsigned WORD_WIDTH     = 64,
  parameter int unsigned CL_WORDS       = 2,
  parameter int unsigned BEAT_WORDS     = 1,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned MEM_LINES      = 64,
  parameter int unsigned REQ_FIFO_DEPTH = 2,
  parameter int unsigned LATENCY        = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic                             req_op_i,
  input  logic [PA_WIDTH-1:0]              req_addr_i,
  input  logic [ID_WIDTH-1:0]              req_id_i,
  input  logic [WORD_WIDTH-1:0]            req_wdata_i,
  input  logic [WORD_WIDTH/8-1:0]          req_be_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [ID_WIDTH-1:0]              rsp_id_o,
  output logic [BEAT_WORDS*WORD_WIDTH-1:0] rsp_data_o,
  output logic                             rsp_last_o,
  output logic                             rsp_is_write_o,
  output logic                             rsp_error_o
);

  localparam int unsigned Bytes    = WORD_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(Bytes);
  localparam int unsigned WidxW    = (CL_WORDS > 1) ? $clog2(CL_WORDS) : 1;
  localparam int unsigned LineOff  = $clog2(CL_WORDS * Bytes);
  localparam int unsigned LineW    = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned NWords   = MEM_LINES * CL_WORDS;
  localparam int unsigned MidxW    = (NWords > 1) ? $clog2(NWords) : 1;
  localparam int unsigned NBeats   = CL_WORDS / BEAT_WORDS;
  localparam int unsigned BeatW    = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam int unsigned CntW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned PtrW     = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int unsigned FcntW    = $clog2(REQ_FIFO_DEPTH + 1);
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
  localparam int unsigned StoreLog = $clog2(NWords * Bytes);
`endif

  typedef struct packed {
    logic                    op;
    logic [PA_WIDTH-1:0]     addr;
    logic [ID_WIDTH-1:0]     id;
    logic [WORD_WIDTH-1:0]   wdata;
    logic [WORD_WIDTH/8-1:0] be;
  } req_t;

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                cur_op_q, cur_op_d;
  logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [LineW-1:0]    cur_line_q, cur_line_d;
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
  logic                cur_err_q, cur_err_d;
`endif
  logic                ready_q, ready_d;

  req_t                fifo_q [REQ_FIFO_DEPTH];
  req_t                fifo_d [REQ_FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FcntW-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic [WORD_WIDTH-1:0] mem_q [NWords];
  logic [WORD_WIDTH-1:0] mem_d [NWords];

  req_t             head;
  logic [LineW-1:0] head_line;
  logic [WidxW-1:0] head_word;
  logic [MidxW-1:0] head_idx;
  logic             head_err;
  logic             push, pop;
  logic             fifo_full, send, last_beat;
  logic [BEAT_WORDS*WORD_WIDTH-1:0] beat_data;

  assign fifo_full   = (fifo_cnt_q == FcntW'(REQ_FIFO_DEPTH));
  // Ready stays low until the first clock after reset is released.
  assign req_ready_o = ready_q && !fifo_full;
  assign push        = req_valid_i && req_ready_o;
  assign send        = (state_q == StSend);
  assign last_beat   = cur_op_q || (beat_q == BeatW'(NBeats - 1));

  // Decode the FIFO head into store coordinates.
  always_comb begin
    head      = fifo_q[rd_ptr_q];
    head_line = LineW'((head.addr >> LineOff) & (MEM_LINES - 1));
    head_word = WidxW'((head.addr >> OffW) & (CL_WORDS - 1));
    head_idx  = MidxW'(int'(head_line) * CL_WORDS + int'(head_word));
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
    head_err  = ((head.addr >> StoreLog) != '0);
`else
    head_err  = 1'b0;
`endif
  end

  // Sequencer: pop in idle, count down the latency, then stream beats.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    cur_op_d   = cur_op_q;
    cur_id_d   = cur_id_q;
    cur_line_d = cur_line_q;
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
    cur_err_d  = cur_err_q;
`endif
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (fifo_cnt_q != '0) begin
          pop        = 1'b1;
          cur_op_d   = head.op;
          cur_id_d   = head.id;
          cur_line_d = head_line;
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
          cur_err_d  = head_err;
`endif
          beat_d     = '0;
          if (LATENCY == 0) begin
            state_d = StSend;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY);
          end
        end
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StSend;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSend: begin
        if (rsp_ready_i) begin
          if (last_beat) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request FIFO with concurrent push and pop.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    ready_d    = 1'b1;
    if (push) begin
      fifo_d[wr_ptr_q] = '{op: req_op_i, addr: req_addr_i, id: req_id_i,
                           wdata: req_wdata_i, be: req_be_i};
      wr_ptr_d = (wr_ptr_q == PtrW'(REQ_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(REQ_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Writes land in the store when popped, so later reads always see them.
  always_comb begin
    mem_d = mem_q;
    if (pop && head.op && !head_err) begin
      for (int b = 0; b < int'(Bytes); b++) begin
        if (head.be[b]) begin
          mem_d[head_idx][b*8 +: 8] = head.wdata[b*8 +: 8];
        end
      end
    end
  end

  // Gather the words of the current beat from the store.
  always_comb begin
    logic [MidxW-1:0] rd_idx;
    beat_data = '0;
    for (int w = 0; w < int'(BEAT_WORDS); w++) begin
      rd_idx = MidxW'(int'(cur_line_q) * CL_WORDS + int'(beat_q) * BEAT_WORDS + w);
      beat_data[w*WORD_WIDTH +: WORD_WIDTH] = mem_q[rd_idx];
    end
  end

  // Outputs are gated by the send state, so reset forces them low at once.
  always_comb begin
    rsp_valid_o    = send;
    rsp_id_o       = send ? cur_id_q : '0;
    rsp_last_o     = send && last_beat;
    rsp_is_write_o = send && cur_op_q;
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
    rsp_error_o    = send && cur_err_q;
    rsp_data_o     = (send && !cur_op_q && !cur_err_q) ? beat_data : '0;
`else
    rsp_error_o    = 1'b0;
    rsp_data_o     = (send && !cur_op_q) ? beat_data : '0;
`endif
  end

  // State, FIFO and store registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      beat_q     <= '0;
      cur_op_q   <= 1'b0;
      cur_id_q   <= '0;
      cur_line_q <= '0;
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
      cur_err_q  <= 1'b0;
`endif
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < int'(REQ_FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      for (int i = 0; i < int'(NWords); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      cur_op_q   <= cur_op_d;
      cur_id_q   <= cur_id_d;
      cur_line_q <= cur_line_d;
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
      cur_err_q  <= cur_err_d;
`endif
      ready_q    <= ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_q     <= fifo_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Directed self-checking bench for hpdcache_mem_responder at default parameters.
module tb_hpdcache_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_op_i;
  logic [55:0] req_addr_i;
  logic [3:0]  req_id_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [3:0]  rsp_id_o;
  logic [63:0] rsp_data_o;
  logic        rsp_last_o;
  logic        rsp_is_write_o;
  logic        rsp_error_o;

  int checks = 0;
  int errors = 0;

  hpdcache_mem_responder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_addr_i     (req_addr_i),
    .req_id_i       (req_id_i),
    .req_wdata_i    (req_wdata_i),
    .req_be_i       (req_be_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_id_o       (rsp_id_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_last_o     (rsp_last_o),
    .rsp_is_write_o (rsp_is_write_o),
    .rsp_error_o    (rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic op, input logic [55:0] addr, input logic [3:0] id,
                          input logic [63:0] wdata, input logic [7:0] be);
    int n = 0;
    @(negedge clk_i);
    req_op_i    = op;
    req_addr_i  = addr;
    req_id_i    = id;
    req_wdata_i = wdata;
    req_be_i    = be;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) check_eq("req_ready_timeout", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [3:0] id, input logic [63:0] data,
                      input logic last, input logic wr, input logic err);
    int n = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check_eq({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
    check_eq({tag, "_id"}, 64'(rsp_id_o), 64'(id));
    check_eq({tag, "_data"}, rsp_data_o, data);
    check_eq({tag, "_last"}, 64'(rsp_last_o), 64'(last));
    check_eq({tag, "_wr"}, 64'(rsp_is_write_o), 64'(wr));
    check_eq({tag, "_err"}, 64'(rsp_error_o), 64'(err));
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = 1'b0;
    req_addr_i  = '0;
    req_id_i    = '0;
    req_wdata_i = '0;
    req_be_i    = '0;
    rsp_ready_i = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_req_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_rsp_last", 64'(rsp_last_o), 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_eq("rel_req_ready_before_clk", 64'(req_ready_o), 64'd0);
    @(posedge clk_i);
    #1 check_eq("rel_req_ready", 64'(req_ready_o), 64'd1);

    // Write then read back-to-back (second accept coincides with first pop).
    send_req(1'b1, 56'h40, 4'd3, 64'h1122334455667788, 8'hFF);
    send_req(1'b0, 56'h40, 4'd4, 64'h0, 8'h00);
    recv("wr1", 4'd3, 64'h0, 1'b1, 1'b1, 1'b0);
    recv("rd1b0", 4'd4, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
    recv("rd1b1", 4'd4, 64'h0, 1'b1, 1'b0, 1'b0);

    // Latency: first valid three clocks after the accepting edge.
    send_req(1'b0, 56'h40, 4'd5, 64'h0, 8'h00);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(posedge clk_i);
      #1 n++;
    end
    check_eq("latency_cycles", 64'(n), 64'd3);
    recv("lat_b0", 4'd5, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
    recv("lat_b1", 4'd5, 64'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: outputs hold while rsp_ready_i is low.
    rsp_ready_i = 1'b0;
    send_req(1'b0, 56'h40, 4'd6, 64'h0, 8'h00);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq("stall_valid", 64'(rsp_valid_o), 64'd1);
      check_eq("stall_data", rsp_data_o, 64'h1122334455667788);
      check_eq("stall_id", 64'(rsp_id_o), 64'd6);
      check_eq("stall_last", 64'(rsp_last_o), 64'd0);
    end
    recv("stall_b0", 4'd6, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
    recv("stall_b1", 4'd6, 64'h0, 1'b1, 1'b0, 1'b0);

    // FIFO fills behind a stalled read; partial byte-enable write.
    rsp_ready_i = 1'b0;
    send_req(1'b0, 56'h40, 4'd7, 64'h0, 8'h00);
    send_req(1'b1, 56'h60, 4'd8, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    send_req(1'b1, 56'h60, 4'd9, 64'h0123456789ABCDEF, 8'h0F);
    check_eq("full_req_ready", 64'(req_ready_o), 64'd0);
    fork
      send_req(1'b0, 56'h60, 4'd10, 64'h0, 8'h00);
      begin
        recv("fa_b0", 4'd7, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
        recv("fa_b1", 4'd7, 64'h0, 1'b1, 1'b0, 1'b0);
        recv("fb_wr", 4'd8, 64'h0, 1'b1, 1'b1, 1'b0);
        recv("fc_wr", 4'd9, 64'h0, 1'b1, 1'b1, 1'b0);
        recv("fd_b0", 4'd10, 64'hFFFFFFFF89ABCDEF, 1'b0, 1'b0, 1'b0);
        recv("fd_b1", 4'd10, 64'h0, 1'b1, 1'b0, 1'b0);
      end
    join

    // Address beyond the store: error with the range check, wrap without it.
    send_req(1'b1, 56'h0, 4'd12, 64'hDEADBEEFCAFEF00D, 8'hFF);
    recv("line0_wr", 4'd12, 64'h0, 1'b1, 1'b1, 1'b0);
    send_req(1'b0, 56'h1000, 4'd11, 64'h0, 8'h00);
`ifdef HPDCACHE_MEM_RESPONDER_RANGE_CHECK_EN
    recv("oor_b0", 4'd11, 64'h0, 1'b0, 1'b0, 1'b1);
    recv("oor_b1", 4'd11, 64'h0, 1'b1, 1'b0, 1'b1);
`else
    recv("wrap_b0", 4'd11, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, 1'b0);
    recv("wrap_b1", 4'd11, 64'h0, 1'b1, 1'b0, 1'b0);
`endif

    // Reset during beat 1 of a read.
    rsp_ready_i = 1'b0;
    send_req(1'b0, 56'h40, 4'd13, 64'h0, 8'h00);
    recv("pre_rst_b0", 4'd13, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check_eq("pre_rst_b1_valid", 64'(rsp_valid_o), 64'd1);
    check_eq("pre_rst_b1_last", 64'(rsp_last_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
    check_eq("mid_rst_last", 64'(rsp_last_o), 64'd0);
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("post_rst_req_ready", 64'(req_ready_o), 64'd1);
    check_eq("post_rst_valid", 64'(rsp_valid_o), 64'd0);
    send_req(1'b0, 56'h40, 4'd14, 64'h0, 8'h00);
    recv("post_rst_b0", 4'd14, 64'h0, 1'b0, 1'b0, 1'b0);
    recv("post_rst_b1", 4'd14, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
